// File: rtl/bitcnt_engine.sv
// bitcnt_engine: multi-cycle CPOP/CLZ/CTZ unit reading and writing the register file.
// Define BITCNT_FAST_EXIT_EN to let COUNT exit as soon as the result is known.
module bitcnt_engine #(
  parameter int XLEN = 32,
  parameter int CW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [4:0]      rs,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [4:0]      rf_ra,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd
);
  typedef enum logic [1:0] {IDLE, READ, COUNT, WRITE} state_t;
  state_t state, state_nxt;
  logic [1:0] op_q;
  logic [4:0] rd_q;
  logic [XLEN-1:0] sreg, sreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt, step;
  logic found, bit_x, last, is_clz, is_cpop;
  always_comb begin
    is_clz = op_q == 2'b01;
    is_cpop = op_q != 2'b01 && op_q != 2'b10;
    bit_x = is_clz ? sreg[XLEN-1] : sreg[0];
    sreg_nxt = is_clz ? sreg << 1 : sreg >> 1;
    cnt_nxt = cnt + CW'(is_cpop ? bit_x : (!found && !bit_x));
    last = step == CW'(XLEN - 1);
`ifdef BITCNT_FAST_EXIT_EN
    last = last || (is_cpop ? sreg_nxt == '0 : bit_x);
`endif
    state_nxt = state == IDLE  ? (start ? READ : IDLE) :
                state == READ  ? COUNT :
                state == COUNT ? (last ? WRITE : COUNT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= '0;
      rd_q <= '0;
      rf_ra <= '0;
      sreg <= '0;
      cnt <= '0;
      step <= '0;
      found <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_q <= op;
        rf_ra <= rs;
        rd_q <= rd;
      end
      if (state == READ) begin
        sreg <= rf_rdata;
        cnt <= '0;
        step <= '0;
        found <= 1'b0;
      end
      if (state == COUNT) begin
        sreg <= sreg_nxt;
        cnt <= cnt_nxt;
        step <= step + CW'(1);
        found <= found | bit_x;
        // result is registered on entry to WRITE so it holds afterwards
        if (last) begin
          rf_wa <= rd_q;
          rf_wd <= {{(XLEN-CW){1'b0}}, cnt_nxt};
        end
      end
    end
  end
  assign busy = state != IDLE;
  assign done = state == WRITE;
  assign rf_we = done && rd_q != '0;
endmodule

// File: doc/bitcnt_engine.md
Name: bitcnt_engine

Overview:
- Multi-cycle bit-manipulation unit for the 32-bit RISC-V bit-counter datapath.
- Acts as the initiator on the register-file port pair: drives one read address, samples the asynchronous read data, and drives the write-enable, write-address and write-data.
- Computes CPOP, CLZ or CTZ of the source register and writes the result back to a destination register.
- Sits beside the decode logic, which issues start/op/rs/rd.

Parameters:
- XLEN, 32, data width; power of two, at least 8.
- CW, $clog2(XLEN)+1, internal count width; the result is zero-extended to XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse, sampled only in IDLE.
- op  in  2  00 CPOP, 01 CLZ, 10 CTZ, 11 reserved (executes as CPOP).
- rs  in  5  source register index.
- rd  in  5  destination register index.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse during WRITE.
- rf_ra  out  5  register-file read address.
- rf_rdata  in  XLEN  register-file asynchronous read data.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  XLEN  register-file write data.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE;
  - busy, done and rf_we are 0;
  - rf_ra, rf_wa and rf_wd are 0;
  - internal shift register, counter and step index are 0.
- Reset asserted mid-operation aborts immediately. No write occurs. After release the engine is in IDLE.
- FSM states: IDLE, READ, COUNT, WRITE.
- IDLE
  - At the edge where start=1, latch op, rs and rd, then go to READ.
  - start=0 stays in IDLE.
  - start in any non-IDLE state is ignored and not queued.
- READ (one cycle)
  - rf_ra = latched rs.
  - At the closing edge: load the shift register from rf_rdata, clear count, step=0, set found=0, go to COUNT.
  - rs=0 reads 0.
- COUNT (XLEN cycles in base build), one bit per edge:
  - CPOP: count += sreg[0]; sreg shifts right.
  - CTZ: examine sreg[0], shift right. If found=0 and the bit is 0, count++. If the bit is 1, set found=1.
  - CLZ: examine sreg[XLEN-1], shift left, same counting rule as CTZ.
  - At the edge where step reaches XLEN-1, go to WRITE.
- WRITE (one cycle)
  - rf_wa = latched rd.
  - rf_wd = zero-extended count.
  - rf_we = 1 only if rd≠0; rd=0 suppresses rf_we.
  - done=1 regardless of rd.
  - At the closing edge, go to IDLE. A start at this edge is ignored.
- rf_ra holds the latched rs outside READ. rf_wa and rf_wd hold their last values outside WRITE.
- Latency (base build), with start sampled at edge 0:
  - READ spans edges 0–1.
  - COUNT steps occur at edges 2..XLEN+1.
  - The register file captures the write at edge XLEN+2 (edge 34 for XLEN=32).
  - busy falls after edge XLEN+2.
  - Back-to-back start is accepted at edge XLEN+3 at the earliest.
- Boundary values:
  - CLZ(0) = CTZ(0) = XLEN.
  - CPOP(all-ones) = XLEN.
  - The counter never wraps, because CW holds XLEN.

Optional Feature:
- Macro: BITCNT_FAST_EXIT_EN.
- When defined, COUNT may exit early:
  - CPOP goes to WRITE at the edge where the post-shift sreg is all-zero.
  - CLZ/CTZ go to WRITE at the edge where a 1 bit is examined.
  - The XLEN-step limit still applies, so CLZ(0) and CTZ(0) take the full latency.
- Results are bit-identical to the base build; only latency varies, minimum write edge is 3.
- When undefined, latency is fixed at XLEN+2 edges for every op and operand.

Test Plan:
- Reset/idle: hold rst_n=0, then release → busy=0, done=0, rf_we=0, rf_wa=0, rf_wd=0, no write observed.
- CPOP: x5=0xF0F0_000F, start op=00 rs=5 rd=6 at edge 0 → single rf_we pulse at edge 34, rf_wa=6, rf_wd=12, done coincident with rf_we.
- CLZ/CTZ: x7=0x0001_0000 → CLZ writes 15, CTZ writes 16. x7=0 → CLZ and CTZ both write 32. x7=0xFFFF_FFFF → CPOP writes 32.
- Reserved op and x0 cases:
  - op=11 with x5=0x0000_0003 → writes 2.
  - rd=0 → done pulses, rf_we stays 0.
  - rs=0 with CPOP → writes 0.
- start held high through an entire operation → exactly one write. Next operation starts at edge 35. busy is continuous between the two operations except during the single IDLE cycle.
- Reset pulse in the middle of COUNT (edge 10) → busy drops immediately, no rf_we ever asserts. With BITCNT_FAST_EXIT_EN: CPOP of 0x0000_0001 writes 1 at edge 3; CTZ of 0x0000_0100 writes 8 at edge 11.
